// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared types and sizes for the register-file writeback arbiter
package regfile_wb_arbiter_pkg;

  localparam int REG_IDX_W = 3;
  localparam int NUM_REGS  = 8;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } src_e;

endpackage

// File: rtl/regfile_wb_arbiter_decoder.sv
// rtl/regfile_wb_arbiter_decoder.sv - binary index to one-hot decoder
module decoder #(
  parameter int IN_W  = 3,
  parameter int OUT_W = 1 << IN_W
) (
  input  logic [IN_W-1:0]  in_idx,
  output logic [OUT_W-1:0] out_onehot
);

  always_comb begin
    out_onehot         = '0;
    out_onehot[in_idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter sharing the register-file write port between ALU and load results
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter bit ZERO_RO = 1'b0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 aluValid,
  input  logic [REG_IDX_W-1:0] aluDest,
  input  logic [DATA_W-1:0]    aluData,
  output logic                 aluReady,
  input  logic                 memValid,
  input  logic [REG_IDX_W-1:0] memDest,
  input  logic [DATA_W-1:0]    memData,
  output logic                 memReady,
  input  logic                 wbStall,
  output logic                 wbValid,
  output logic [REG_IDX_W-1:0] wbDest,
  output logic [DATA_W-1:0]    wbData,
  output logic [NUM_REGS-1:0]  wbEn,
  output logic [15:0]          collCnt
);

  src_e                 last_grant_q, last_grant_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [REG_IDX_W-1:0] wb_dest_q, wb_dest_d;
  logic [DATA_W-1:0]    wb_data_q, wb_data_d;
  logic [NUM_REGS-1:0]  wb_en_q, wb_en_d;
  logic [15:0]          coll_cnt_q, coll_cnt_d;

  logic                 grant_alu, grant_mem, xfer, discard;
  logic [REG_IDX_W-1:0] win_dest;
  logic [DATA_W-1:0]    win_data;
  logic [NUM_REGS-1:0]  dest_onehot;

  // On a tie the source that did not win last time gets the port.
  always_comb begin
    grant_alu = aluValid && (!memValid || (last_grant_q == SRC_MEM));
    grant_mem = memValid && !grant_alu;
    aluReady  = grant_alu && !wbStall;
    memReady  = grant_mem && !wbStall;
    xfer      = aluReady || memReady;
    win_dest  = grant_alu ? aluDest : memDest;
    win_data  = grant_alu ? aluData : memData;
    discard   = ZERO_RO && (win_dest == '0);
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wb_valid_d   = wb_valid_q;
    wb_dest_d    = wb_dest_q;
    wb_data_d    = wb_data_q;
    coll_cnt_d   = coll_cnt_q;
    if (!wbStall) begin
      wb_valid_d = xfer && !discard;
      if (xfer) begin
        last_grant_d = grant_alu ? SRC_ALU : SRC_MEM;
        wb_dest_d    = win_dest;
        wb_data_d    = win_data;
      end
      if (aluValid && memValid && (coll_cnt_q != 16'hFFFF)) begin
        coll_cnt_d = coll_cnt_q + 16'd1;
      end
    end
  end

  decoder #(.IN_W(REG_IDX_W), .OUT_W(NUM_REGS)) u_dec (
    .in_idx     (wb_dest_d),
    .out_onehot (dest_onehot)
  );

  always_comb begin
    wb_en_d = dest_onehot & {NUM_REGS{wb_valid_d}};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= SRC_MEM;
      wb_valid_q   <= 1'b0;
      wb_dest_q    <= '0;
      wb_data_q    <= '0;
      wb_en_q      <= '0;
      coll_cnt_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wb_valid_q   <= wb_valid_d;
      wb_dest_q    <= wb_dest_d;
      wb_data_q    <= wb_data_d;
      wb_en_q      <= wb_en_d;
      coll_cnt_q   <= coll_cnt_d;
    end
  end

  assign wbValid = wb_valid_q;
  assign wbDest  = wb_dest_q;
  assign wbData  = wb_data_q;
  assign wbEn    = wb_en_q;
  assign collCnt = coll_cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - self-checking bench for regfile_wb_arbiter with ZERO_RO=0 and ZERO_RO=1 instances
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        aluValid, memValid, wbStall;
  logic [2:0]  aluDest, memDest;
  logic [31:0] aluData, memData;

  logic        aluReady0, memReady0, wbValid0, aluReady1, memReady1, wbValid1;
  logic [2:0]  wbDest0, wbDest1;
  logic [31:0] wbData0, wbData1;
  logic [7:0]  wbEn0, wbEn1;
  logic [15:0] collCnt0, collCnt1;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_W(32), .ZERO_RO(1'b0)) u_dut0 (
    .clk(clk), .reset(reset),
    .aluValid(aluValid), .aluDest(aluDest), .aluData(aluData), .aluReady(aluReady0),
    .memValid(memValid), .memDest(memDest), .memData(memData), .memReady(memReady0),
    .wbStall(wbStall), .wbValid(wbValid0), .wbDest(wbDest0), .wbData(wbData0),
    .wbEn(wbEn0), .collCnt(collCnt0)
  );

  regfile_wb_arbiter #(.DATA_W(32), .ZERO_RO(1'b1)) u_dut1 (
    .clk(clk), .reset(reset),
    .aluValid(aluValid), .aluDest(aluDest), .aluData(aluData), .aluReady(aluReady1),
    .memValid(memValid), .memDest(memDest), .memData(memData), .memReady(memReady1),
    .wbStall(wbStall), .wbValid(wbValid1), .wbDest(wbDest1), .wbData(wbData1),
    .wbEn(wbEn1), .collCnt(collCnt1)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Model: "last" holds who won previously (0 = ALU, 1 = MEM).
  int          m_last;
  bit          m_valid0, m_valid1;
  int          m_dest;
  logic [31:0] m_data;
  int          m_cnt;

  function automatic int winner();
    if (aluValid && memValid) return (m_last == 0) ? 1 : 0;
    if (aluValid) return 0;
    if (memValid) return 1;
    return -1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_last = 1; m_valid0 = 0; m_valid1 = 0; m_dest = 0; m_data = 0; m_cnt = 0;
    end else if (!wbStall) begin
      int w;
      w = winner();
      if (aluValid && memValid && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (w < 0) begin
        m_valid0 = 0; m_valid1 = 0;
      end else begin
        m_last   = w;
        m_dest   = (w == 0) ? int'(aluDest) : int'(memDest);
        m_data   = (w == 0) ? aluData : memData;
        m_valid0 = 1;
        m_valid1 = (m_dest != 0);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      int w;
      w = wbStall ? -1 : winner();
      chk("aluReady0", 64'(aluReady0), 64'(w == 0));
      chk("memReady0", 64'(memReady0), 64'(w == 1));
      chk("aluReady1", 64'(aluReady1), 64'(w == 0));
      chk("memReady1", 64'(memReady1), 64'(w == 1));
      chk("wbValid0", 64'(wbValid0), 64'(m_valid0));
      chk("wbValid1", 64'(wbValid1), 64'(m_valid1));
      chk("wbDest0", 64'(wbDest0), 64'(m_dest));
      chk("wbData0", 64'(wbData0), 64'(m_data));
      chk("wbDest1", 64'(wbDest1), 64'(m_dest));
      chk("wbData1", 64'(wbData1), 64'(m_data));
      chk("wbEn0", 64'(wbEn0), m_valid0 ? (64'd1 << m_dest) : 64'd0);
      chk("wbEn1", 64'(wbEn1), m_valid1 ? (64'd1 << m_dest) : 64'd0);
      chk("collCnt0", 64'(collCnt0), 64'(m_cnt));
      chk("collCnt1", 64'(collCnt1), 64'(m_cnt));
    end
  end

  // Inputs change 2 time units after the falling edge, clear of both edges.
  task automatic cyc();
    @(negedge clk);
    #2;
  endtask

  task automatic idle();
    aluValid = 0; memValid = 0; wbStall = 0;
  endtask

  logic [7:0]  exp_en [4];
  logic [15:0] cnt_hold;

  initial begin
    reset = 1; aluDest = 0; memDest = 0; aluData = 0; memData = 0;
    idle();
    repeat (3) cyc();
    chk("rst_wbValid", 64'(wbValid0), 64'd0);
    chk("rst_wbEn", 64'(wbEn0), 64'd0);
    chk("rst_wbData", 64'(wbData0), 64'd0);
    chk("rst_collCnt", 64'(collCnt0), 64'd0);
    reset = 0;

    aluValid = 1; aluDest = 3; aluData = 32'hA5;
    #1 chk("t1_aluReady", 64'(aluReady0), 64'd1);
    cyc();
    aluValid = 0;
    chk("t1_wbValid", 64'(wbValid0), 64'd1);
    chk("t1_wbDest", 64'(wbDest0), 64'd3);
    chk("t1_wbEn", 64'(wbEn0), 64'h08);
    chk("t1_wbData", 64'(wbData0), 64'hA5);
    cyc();

    reset = 1;
    cyc();
    reset = 0;
    exp_en[0] = 8'h02; exp_en[1] = 8'h04; exp_en[2] = 8'h02; exp_en[3] = 8'h04;
    aluValid = 1; aluDest = 1; aluData = 32'h11;
    memValid = 1; memDest = 2; memData = 32'h22;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("t2_wbEn%0d", i), 64'(wbEn0), 64'(exp_en[i]));
    end
    idle();
    chk("t2_collCnt", 64'(collCnt0), 64'd4);

    aluValid = 1; aluDest = 5; aluData = 32'h55;
    cyc();
    wbStall = 1; aluData = 32'h56; memValid = 1; memDest = 6; memData = 32'h66;
    cnt_hold = collCnt0;
    #1 chk("t3_aluReady", 64'(aluReady0), 64'd0);
    chk("t3_memReady", 64'(memReady0), 64'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("t3_wbEn%0d", i), 64'(wbEn0), 64'h20);
      chk($sformatf("t3_collCnt%0d", i), 64'(collCnt0), 64'(cnt_hold));
    end
    wbStall = 0;
    cyc();
    aluValid = 0; memValid = 0;
    chk("t3_rel_wbValid", 64'(wbValid0), 64'd1);
    chk("t3_rel_wbEn", 64'(wbEn0), 64'h40);
    cyc();

    memValid = 1; memDest = 0; memData = 32'h77;
    #1 chk("t4_memReady1", 64'(memReady1), 64'd1);
    cyc();
    memValid = 0;
    chk("t4_wbValid1", 64'(wbValid1), 64'd0);
    chk("t4_wbEn1", 64'(wbEn1), 64'h00);
    chk("t4_wbEn0", 64'(wbEn0), 64'h01);
    cyc();

    aluValid = 1; aluDest = 7; aluData = 32'h1;
    memValid = 1; memDest = 7; memData = 32'h2;
    cyc();
    aluValid = 0;
    chk("t5_first_wbData", 64'(wbData0), 64'h1);
    chk("t5_first_wbEn", 64'(wbEn0), 64'h80);
    cyc();
    memValid = 0;
    chk("t5_last_wbData", 64'(wbData0), 64'h2);
    chk("t5_last_wbEn", 64'(wbEn0), 64'h80);
    cyc();

    aluValid = 1; aluDest = 4; aluData = 32'h99;
    cyc();
    aluValid = 0;
    chk("t6_pre_wbValid", 64'(wbValid0), 64'd1);
    #1 reset = 1;
    #1;
    chk("t6_async_wbValid", 64'(wbValid0), 64'd0);
    chk("t6_async_wbEn", 64'(wbEn0), 64'd0);
    chk("t6_async_collCnt", 64'(collCnt0), 64'd0);
    cyc();
    reset = 0;
    aluValid = 1; memValid = 1; aluDest = 2; memDest = 3; aluData = 32'hC; memData = 32'hD;
    cyc();
    idle();
    chk("t6_restart_wbEn", 64'(wbEn0), 64'h04);
    repeat (2) cyc();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected finish before 20000");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1);
  end

endmodule
